// File: rtl/pc_ras_unit.sv
// pc_ras_unit
//   Fetch-stage program counter with an integrated circular return-address
//   stack. PS selects the next-PC function:
//     hold, sequential, absolute jump, relative branch,
//     call-relative, call-absolute, return, and a reserved code.
//   Call pushes PC+4. Return pops the top entry into PC.
//   stall freezes all architectural state.
//
// Ports
//   clock, reset   rising-edge clock; asynchronous active-high reset
//   PS[2:0]        PC function select
//   stall          freeze PC/RAS, PS ignored, status pulses drop
//   in             absolute target or word offset (offset is in*4)
//   PC             registered program counter
//   PC4            PC + 4 (combinational)
//   ras_top        top stack entry, 0 when empty
//   ras_count      valid entries, 0..RAS_DEPTH
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   ras_overflow   one-cycle pulse after a push while full
//   ras_underflow  one-cycle pulse after a return while empty
module pc_ras_unit #(
    parameter int                 WIDTH        = 64,
    parameter int                 RAS_DEPTH    = 8,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   PS,
    input  logic                         stall,
    input  logic [WIDTH-1:0]             in,
    output logic [WIDTH-1:0]             PC,
    output logic [WIDTH-1:0]             PC4,
    output logic [WIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        PS_HOLD     = 3'b000,
        PS_SEQ      = 3'b001,
        PS_JUMP     = 3'b010,
        PS_BRANCH   = 3'b011,
        PS_CALL_REL = 3'b100,
        PS_CALL_ABS = 3'b101,
        PS_RET      = 3'b110,
        PS_RSVD     = 3'b111
    } ps_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] mem_d [RAS_DEPTH];

    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] top;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             empty;

    assign pc4    = pc_q + WIDTH'(4);
    assign offset = {in[WIDTH-3:0], 2'b00};
    assign empty  = (cnt_q == '0);
    // Storage is never cleared, so gate the read to keep stale data hidden.
    assign top    = empty ? '0 : mem_q[ptr_q];
    // Pointer width equals log2(depth), so +1 wraps naturally; when full this
    // lands on the oldest entry, giving the circular overwrite for free.
    assign wr_ptr = ptr_q + 1'b1;

    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
        mem_d = mem_q;
        if (!stall) begin
            case (ps_e'(PS))
                PS_SEQ:      pc_d = pc4;
                PS_JUMP:     pc_d = in;
                PS_BRANCH:   pc_d = pc4 + offset;
                PS_CALL_REL: begin pc_d = pc4 + offset; push = 1'b1; end
                PS_CALL_ABS: begin pc_d = in;           push = 1'b1; end
                PS_RET: begin
                    if (!empty) begin
                        pc_d  = top;
                        ptr_d = ptr_q - 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        pc_d  = in;
                        unf_d = 1'b1;
                    end
                end
                default: ;  // hold and reserved
            endcase
        end
        if (push) begin
            ptr_d         = wr_ptr;
            mem_d[wr_ptr] = pc4;
            if (cnt_q == FULL_CNT) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage has no reset; only count/pointer define validity.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign PC            = pc_q;
    assign PC4           = pc4;
    assign ras_top       = top;
    assign ras_count     = cnt_q;
    assign ras_empty     = empty;
    assign ras_full      = (cnt_q == FULL_CNT);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
module tb_pc_ras_unit;
    localparam int          W  = 64;
    localparam int          D  = 8;
    localparam logic [63:0] RV = 64'h100;

    logic          clock, reset, stall;
    logic [2:0]    PS;
    logic [W-1:0]  in_d, PC, PC4, ras_top;
    logic [3:0]    ras_count;
    logic          ras_empty, ras_full, ras_overflow, ras_underflow;

    int tests_run = 0;
    int failures  = 0;

    // Reference model: a bounded LIFO of return addresses.
    logic [63:0] m_pc;
    logic [63:0] m_stk[$];
    logic        m_ovf, m_unf;

    pc_ras_unit #(.WIDTH(W), .RAS_DEPTH(D), .RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset), .PS(PS), .stall(stall), .in(in_d),
        .PC(PC), .PC4(PC4), .ras_top(ras_top), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic model_reset();
        m_pc = RV;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic drive(input logic [2:0] ps, input logic [63:0] d, input logic st);
        logic [63:0] nxt4, off;
        @(negedge clock);
        PS = ps; in_d = d; stall = st;
        @(posedge clock);
        nxt4 = m_pc + 64'd4;
        off  = d << 2;
        m_ovf = 0;
        m_unf = 0;
        if (!st) begin
            case (ps)
                3'd1: m_pc = nxt4;
                3'd2: m_pc = d;
                3'd3: m_pc = nxt4 + off;
                3'd4, 3'd5: begin
                    if (m_stk.size() == D) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1;
                    end
                    m_stk.push_back(nxt4);
                    m_pc = (ps == 3'd4) ? nxt4 + off : d;
                end
                3'd6: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_pc = d; m_unf = 1; end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (PC !== RV) begin failures++; $display("FAIL reset_pc got %h want %h", PC, RV); end
        tests_run++; if (ras_count !== 4'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0)
            begin failures++; $display("FAIL reset_ras got cnt=%0d e=%b f=%b want 0/1/0", ras_count, ras_empty, ras_full); end
        tests_run++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0 || ras_top !== 64'd0)
            begin failures++; $display("FAIL reset_status got o=%b u=%b top=%h want 0/0/0", ras_overflow, ras_underflow, ras_top); end
        @(negedge clock);
        reset = 0;
        model_reset();
        #1;
        tests_run++; if (PC4 !== RV + 64'd4) begin failures++; $display("FAIL reset_pc4 got %h want %h", PC4, RV + 64'd4); end
    endtask

    task automatic test_seq();
        for (int k = 1; k <= 3; k++) begin
            drive(3'b001, 64'd0, 0);
            tests_run++; if (PC !== RV + 64'(4*k)) begin failures++; $display("FAIL seq_pc%0d got %h want %h", k, PC, RV + 64'(4*k)); end
            tests_run++; if (PC4 !== PC + 64'd4 || ras_empty !== 1'b1)
                begin failures++; $display("FAIL seq_pc4_%0d got %h e=%b want %h e=1", k, PC4, ras_empty, PC + 64'd4); end
        end
    endtask

    task automatic test_branch();
        drive(3'b010, 64'h200, 0);
        drive(3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        tests_run++; if (PC !== 64'h1FC) begin failures++; $display("FAIL branch_neg got %h want 1fc", PC); end
        drive(3'b010, 64'h4000, 0);
        tests_run++; if (PC !== 64'h4000) begin failures++; $display("FAIL jump got %h want 4000", PC); end
        drive(3'b001, 64'h0, 1);
        tests_run++; if (PC !== 64'h4000) begin failures++; $display("FAIL stall_hold got %h want 4000", PC); end
        drive(3'b111, 64'h0, 0);
        tests_run++; if (PC !== 64'h4000 || ras_count !== 4'd0) begin failures++; $display("FAIL reserved got %h cnt=%0d want 4000 cnt=0", PC, ras_count); end
    endtask

    task automatic test_call_return();
        drive(3'b010, 64'h1000, 0);
        drive(3'b100, 64'h10, 0);
        tests_run++; if (PC !== 64'h1044 || ras_top !== 64'h1004 || ras_count !== 4'd1)
            begin failures++; $display("FAIL call_rel got pc=%h top=%h cnt=%0d want 1044/1004/1", PC, ras_top, ras_count); end
        drive(3'b101, 64'h8000, 0);
        tests_run++; if (PC !== 64'h8000 || ras_top !== 64'h1048 || ras_count !== 4'd2)
            begin failures++; $display("FAIL call_abs got pc=%h top=%h cnt=%0d want 8000/1048/2", PC, ras_top, ras_count); end
        drive(3'b110, 64'h0, 0);
        tests_run++; if (PC !== 64'h1048 || ras_count !== 4'd1) begin failures++; $display("FAIL ret1 got pc=%h cnt=%0d want 1048/1", PC, ras_count); end
        drive(3'b110, 64'h0, 0);
        tests_run++; if (PC !== 64'h1004 || ras_count !== 4'd0 || ras_empty !== 1'b1 || ras_top !== 64'd0)
            begin failures++; $display("FAIL ret2 got pc=%h cnt=%0d e=%b top=%h want 1004/0/1/0", PC, ras_count, ras_empty, ras_top); end
    endtask

    task automatic test_overflow();
        drive(3'b010, 64'h0, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(3'b101, 64'(16*k), 0);
            tests_run++; if (ras_overflow !== (k == 9) || ras_count !== 4'(k > 8 ? 8 : k))
                begin failures++; $display("FAIL ovf_call%0d got o=%b cnt=%0d want o=%b cnt=%0d", k, ras_overflow, ras_count, (k == 9), (k > 8 ? 8 : k)); end
        end
        tests_run++; if (ras_full !== 1'b1) begin failures++; $display("FAIL ovf_full got %b want 1", ras_full); end
        for (int k = 9; k >= 2; k--) begin
            drive(3'b110, 64'h0, 0);
            tests_run++; if (PC !== 64'(16*(k-1) + 4) || ras_overflow !== 1'b0)
                begin failures++; $display("FAIL ovf_ret%0d got pc=%h o=%b want %h o=0", k, PC, ras_overflow, 64'(16*(k-1) + 4)); end
        end
        tests_run++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL ovf_drained got e=%b want 1", ras_empty); end
    endtask

    task automatic test_underflow();
        drive(3'b110, 64'h300, 0);
        tests_run++; if (PC !== 64'h300 || ras_count !== 4'd0 || ras_underflow !== 1'b1)
            begin failures++; $display("FAIL unf got pc=%h cnt=%0d u=%b want 300/0/1", PC, ras_count, ras_underflow); end
        drive(3'b000, 64'h0, 0);
        tests_run++; if (ras_underflow !== 1'b0 || PC !== 64'h300) begin failures++; $display("FAIL unf_pulse got u=%b pc=%h want 0/300", ras_underflow, PC); end
        drive(3'b110, 64'h340, 1);
        tests_run++; if (ras_underflow !== 1'b0 || PC !== 64'h300) begin failures++; $display("FAIL unf_stall got u=%b pc=%h want 0/300", ras_underflow, PC); end
    endtask

    task automatic test_wrap_async_reset();
        drive(3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        drive(3'b001, 64'h0, 0);
        tests_run++; if (PC !== 64'h0) begin failures++; $display("FAIL wrap got %h want 0", PC); end
        for (int k = 0; k < 3; k++) drive(3'b101, 64'h500, 0);
        tests_run++; if (ras_count !== 4'd3) begin failures++; $display("FAIL pre_reset_cnt got %0d want 3", ras_count); end
        @(negedge clock);
        PS = 3'b000;
        #2 reset = 1;
        #1;
        tests_run++; if (PC !== RV || ras_count !== 4'd0 || ras_empty !== 1'b1)
            begin failures++; $display("FAIL async_reset got pc=%h cnt=%0d want %h/0", PC, ras_count, RV); end
        #1 reset = 0;
        model_reset();
    endtask

    task automatic test_random();
        logic [2:0]  ps;
        logic [63:0] d;
        logic        st;
        for (int i = 0; i < 400; i++) begin
            ps = 3'($urandom_range(0, 7));
            // Bias toward calls/returns so the stack fills and drains.
            if ($urandom_range(0, 3) == 0) ps = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd6;
            d  = {$urandom, $urandom};
            st = ($urandom_range(0, 7) == 0);
            drive(ps, d, st);
            tests_run++; if (PC !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got %h want %h", i, PC, m_pc); end
            tests_run++; if (ras_count !== 4'(m_stk.size()) || ras_top !== (m_stk.size() ? m_stk[$] : 64'd0))
                begin failures++; $display("FAIL rnd_ras[%0d] got cnt=%0d top=%h want cnt=%0d", i, ras_count, ras_top, m_stk.size()); end
            tests_run++; if (ras_overflow !== m_ovf || ras_underflow !== m_unf || ras_full !== (m_stk.size() == D))
                begin failures++; $display("FAIL rnd_status[%0d] got o=%b u=%b f=%b want o=%b u=%b", i, ras_overflow, ras_underflow, ras_full, m_ovf, m_unf); end
        end
    endtask

    initial begin
        reset = 1; PS = 3'b000; in_d = '0; stall = 0;
        model_reset();
        test_reset();
        test_seq();
        test_branch();
        test_call_return();
        test_overflow();
        test_underflow();
        test_wrap_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program counter with an integrated circular return-address stack (RAS), replacing the fixed 64-bit counter in the fetch stage. Supports hold, sequential, absolute-branch and relative-branch updates plus call (push PC+4) and return (pop) modes, with a stall input and registered overflow/underflow status. Sits between the control unit (PS, stall) and instruction memory (PC), with branch targets arriving on `in`.

## Interface
- WIDTH, 64, address width in bits (≥8)
- RAS_DEPTH, 8, return-stack entries (power of two, ≥2)
- RESET_VECTOR, 0, PC value after reset

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- PS  input  3  PC function select (see Operation)
- stall  input  1  when high, PC and RAS are frozen; PS ignored
- in  input  WIDTH  branch operand (absolute target or word offset)
- PC  output  WIDTH  current program counter (register)
- PC4  output  WIDTH  PC + 4, combinational
- ras_top  output  WIDTH  top RAS entry, combinational; 0 when empty
- ras_count  output  $clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH
- ras_empty  output  1  ras_count == 0
- ras_full  output  1  ras_count == RAS_DEPTH
- ras_overflow  output  1  registered one-cycle pulse: push while full
- ras_underflow  output  1  registered one-cycle pulse: pop while empty

## Operation
- Reset: PC=RESET_VECTOR, ras_count=0, top pointer=0, overflow/underflow=0. RAS storage not cleared (unobservable; ras_top gated to 0 when empty).
- All arithmetic modulo 2^WIDTH; offset term = {in[WIDTH-3:0],2'b00}; carries discarded.
- PS encoding (applied on rising edge when stall=0):
  - 000 hold: PC unchanged.
  - 001 seq: PC ← PC4.
  - 010 jump: PC ← in.
  - 011 branch: PC ← PC4 + in*4.
  - 100 call-rel: push PC4; PC ← PC4 + in*4.
  - 101 call-abs: push PC4; PC ← in.
  - 110 return: if not empty, PC ← ras_top, pop; if empty, PC ← in, count stays 0, ras_underflow=1 next cycle.
  - 111 reserved: treated as hold; no RAS change.
- Push: top pointer advances (mod RAS_DEPTH), entry written; count increments saturating at RAS_DEPTH. Push while full overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_overflow=1 next cycle.
- Pop: top pointer retreats (mod RAS_DEPTH); count decrements.
- stall=1: PC, pointer, count and storage hold; ras_overflow/ras_underflow deassert (0).
- ras_overflow/ras_underflow: 1 only in the cycle after the offending edge, else 0.

## Timing
- PC, ras_count, pointers, status pulses update on the rising clock edge; one-cycle latency from PS/in to PC.
- PC4, ras_top, ras_empty, ras_full combinational from registered state; valid same cycle.
- Return uses ras_top of the current cycle; a call immediately following a return (back-to-back cycles) sees the post-pop state.
- Reset asserted mid-operation: all registers take reset values immediately (asynchronous), independent of clock; first update on the first rising edge after reset deasserts.
- One PC update per cycle maximum; no multi-cycle states.

## Test plan
- Reset with RESET_VECTOR=0x100; release; PS=001 for 3 edges -> PC 0x100, 0x104, 0x108, 0x10C; PC4=PC+4 each cycle; ras_empty=1.
- PC=0x200, PS=011, in=0xFFFF_FFFF_FFFF_FFFE (−2) -> PC=0x1FC; then PS=010, in=0x4000 -> PC=0x4000; stall=1 with PS=001 -> PC stays 0x4000.
- PC=0x1000, PS=100, in=0x10 -> PC=0x1044, ras_top=0x1004, count=1; PS=101, in=0x8000 -> PC=0x8000, ras_top=0x1048, count=2; PS=110 twice -> PC=0x1048 then 0x1004, count 0, ras_empty=1.
- RAS_DEPTH=8: 9 consecutive PS=101 calls from PC=0 with in=0x10*k -> count saturates at 8, ras_overflow pulses once after 9th call; 8 returns yield the newest 8 return addresses in LIFO order, first-pushed lost.
- Empty RAS, PS=110, in=0x300 -> PC=0x300, count 0, ras_underflow=1 for exactly one cycle.
- Wrap: PC=0xFFFF_FFFF_FFFF_FFFC, PS=001 -> PC=0; assert reset asynchronously between edges with count=3 -> PC=RESET_VECTOR, count=0 immediately.
